data_ram_slave: RTL and testbench

Responder end of the memory-stage data RAM interface: accepts the `ram_request`/`ram_w_request` address/data strobes that the `mem` stage issues and returns read data with a configurable number of wait states. It holds the word-addressed data storage, signals completion with a one-cycle `ram_ready_o`, and drives `ram_stall_o` so the pipeline freezes while an access is outstanding. Byte and halfword merging stays in the `mem` stage; this block is word-only.

---
 rtl/data_ram_slave_pkg.sv | 21 ++
 rtl/data_ram_slave_ram_array.sv | 27 ++
 rtl/data_ram_slave.sv | 144 ++++++++++++++
 tb/tb_data_ram_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_slave_pkg.sv
// Shared types and constants for the memory-stage data RAM responder.
// Holds the FSM state encoding, index-width helpers, halt address and zero word.
package data_ram_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } ram_state_e;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;
    localparam int unsigned WORD_IDX_W          = $clog2(DEFAULT_DEPTH_WORDS);

    localparam logic [31:0] HALT_ADDR = 32'h0000_3FFC;
    localparam logic [31:0] ZERO_DATA = '0;

    function automatic int unsigned word_idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_ram_slave_ram_array.sv
// Single-port word array: synchronous write, registered read.
// Kept free of reset and control logic so an SRAM macro can drop in here.
module data_ram_slave_ram_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IDX_W       = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/data_ram_slave.sv
// Data RAM responder for the mem stage: word-only storage with WAIT_CYCLES wait states.
// Optional sticky halt on a write to HALT_ADDR is enabled by defining RAM_HALT_EN.
module data_ram_slave
    import data_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ram_request_i,
    input  logic                  ram_w_request_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_ready_o,
    output logic                  ram_stall_o,
    output logic                  ram_err_o,
    output logic                  halt_o
);

    localparam int unsigned IDX_W     = word_idx_width(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    ram_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [IDX_W-1:0]      arr_idx;
    logic                  capture;
    logic                  rd_en;
    logic                  wr_en;
    logic                  addr_err;
    logic [1:0]            unused_addr_lsb;

    assign unused_addr_lsb = ram_addr_i[1:0];

    // Any set bit above the index range means the word lies beyond DEPTH_WORDS.
    assign addr_err    = |ram_addr_i[ADDR_WIDTH-1:IDX_W+2];
    assign capture     = (state_q == S_IDLE) && ram_request_i;
    assign ram_ready_o = (state_q == S_RESP) && ram_request_i;
    assign ram_err_o   = ram_ready_o && err_q;
    assign ram_stall_o = ram_request_i & ~ram_ready_o;

    // With no wait states the array must be read in the capture cycle itself.
    assign rd_en   = (capture && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign wr_en   = ram_ready_o && write_q && !err_q;
    assign arr_idx = (state_q == S_IDLE) ? ram_addr_i[IDX_W+1:2] : idx_q;

    assign ram_data_o = (state_q != S_RESP) ? hold_q :
                        err_q               ? DATA_WIDTH'(ZERO_DATA) : arr_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ram_request_i) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ram_request_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= ram_addr_i[IDX_W+1:2];
                write_q <= ram_w_request_i;
                err_q   <= addr_err;
            end
            if (state_q == S_RESP) begin
                hold_q <= ram_data_o;
            end
        end
    end

    data_ram_slave_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_ram_array (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .re_i    (rd_en),
        .addr_i  (arr_idx),
        .wdata_i (ram_data_i),
        .rdata_o (arr_rdata)
    );

`ifdef RAM_HALT_EN
    localparam logic [ADDR_WIDTH-1:0] HALT_A = ADDR_WIDTH'(HALT_ADDR);

    logic halt_hit_q;
    logic halt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_hit_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            if (capture) begin
                halt_hit_q <= (ram_addr_i[ADDR_WIDTH-1:2] == HALT_A[ADDR_WIDTH-1:2]);
            end
            if (ram_ready_o && write_q && halt_hit_q) begin
                halt_q <= 1'b1;
            end
        end
    end

    assign halt_o = halt_q;
`else
    assign halt_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed bench for data_ram_slave: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, wreq;
    logic [31:0] addr, wdata, rdata;
    logic        ready, stall, err, halt;

    logic        req0, wreq0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, stall0, err0, halt0;

    int checks = 0;
    int errors = 0;

    data_ram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(4096), .WAIT_CYCLES(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .ram_request_i(req), .ram_w_request_i(wreq),
        .ram_addr_i(addr), .ram_data_i(wdata), .ram_data_o(rdata),
        .ram_ready_o(ready), .ram_stall_o(stall), .ram_err_o(err), .halt_o(halt)
    );

    data_ram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .ram_request_i(req0), .ram_w_request_i(wreq0),
        .ram_addr_i(addr0), .ram_data_i(wdata0), .ram_data_o(rdata0),
        .ram_ready_o(ready0), .ram_stall_o(stall0), .ram_err_o(err0), .halt_o(halt0)
    );

    // One access on dut; reports ready cycle index, response data/err and stall shape.
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit glitch, output logic [31:0] rd, output logic er,
                       output int cyc, output bit stall_ok);
        @(posedge clk); #1;
        req = 1'b1; wreq = w; addr = a; wdata = d;
        cyc = -1; stall_ok = 1'b1; rd = '0; er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                cyc = i; rd = rdata; er = err;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (glitch && i == 1) begin
                addr = a ^ 32'h4; wreq = ~w; wdata = 32'hFFFF_FFFF;
            end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL acc_timeout addr %h got no ready within 20 cycles", a);
        end
        @(posedge clk); #1;
        req = 1'b0; wreq = 1'b0;
    endtask

    task automatic b_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req0 = 1'b1; wreq0 = 1'b1; addr0 = a; wdata0 = d;
        @(posedge clk);
        @(posedge clk); #1;
        req0 = 1'b0; wreq0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 0; wreq = 0; addr = '0; wdata = '0;
        req0 = 0; wreq0 = 0; addr0 = '0; wdata0 = '0;
        #3;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", rdata); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rst_halt got %b exp 0", halt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_lo got %b exp 0", stall); end
        req = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_hi got %b exp 1", stall); end
        req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_read;
        logic [31:0] rd; logic er; int cyc; bit sok;
        acc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, rd, er, cyc, sok);
        acc(1'b0, 32'h40, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (cyc != 3) begin errors++; $display("FAIL read_latency got %0d exp 3", cyc); end
        checks++; if (!sok) begin errors++; $display("FAIL read_stall got bad exp high c0-2 low c3"); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err got %b exp 0", er); end
        @(negedge clk);
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_hold got %h exp deadbeef", rdata); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er; int cyc; bit sok;
        acc(1'b1, 32'h44, 32'h1111_1111, 1'b0, rd, er, cyc, sok);
        acc(1'b1, 32'h44, 32'h1234_5678, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL wr_old_word got %h exp 11111111", rd); end
        acc(1'b0, 32'h44, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback got %h exp 12345678", rd); end
        acc(1'b0, 32'h47, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_lsb_ignored got %h exp 12345678", rd); end
        acc(1'b0, 32'h44, 32'h0, 1'b1, rd, er, cyc, sok);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL glitch_data got %h exp 12345678", rd); end
        acc(1'b0, 32'h40, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL glitch_nowrite40 got %h exp deadbeef", rd); end
        acc(1'b0, 32'h44, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL glitch_nowrite44 got %h exp 12345678", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic er; int cyc; bit sok; int pulses;
        acc(1'b1, 32'h48, 32'h5555_5555, 1'b0, rd, er, cyc, sok);
        @(posedge clk); #1;
        req = 1'b1; wreq = 1'b1; addr = 32'h48; wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        @(posedge clk); #1;
        req = 1'b0; wreq = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_ready got %0d pulses exp 0", pulses); end
        acc(1'b0, 32'h48, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h5555_5555) begin errors++; $display("FAIL abort_nowrite got %h exp 55555555", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er; int cyc; bit sok;
        acc(1'b1, 32'h0, 32'h0BAD_C0DE, 1'b0, rd, er, cyc, sok);
        acc(1'b0, 32'h4000, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", rd); end
        acc(1'b1, 32'h4000, 32'hCAFE_F00D, 1'b0, rd, er, cyc, sok);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", er); end
        acc(1'b0, 32'h0, 32'h0, 1'b0, rd, er, cyc, sok);
        checks++; if (rd !== 32'h0BAD_C0DE) begin errors++; $display("FAIL oor_wr_dropped got %h exp 0badc0de", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL inrange_err got %b exp 0", er); end
    endtask

    task automatic test_halt;
        logic [31:0] rd; logic er; int cyc; bit sok; logic exp_halt;
`ifdef RAM_HALT_EN
        exp_halt = 1'b1;
`else
        exp_halt = 1'b0;
`endif
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_before got %b exp 0", halt); end
        acc(1'b1, data_ram_slave_pkg::HALT_ADDR, 32'h600D_F00D, 1'b0, rd, er, cyc, sok);
        checks++; if (halt !== exp_halt) begin errors++; $display("FAIL halt_set got %b exp %b", halt, exp_halt); end
        repeat (3) @(negedge clk);
        checks++; if (halt !== exp_halt) begin errors++; $display("FAIL halt_sticky got %b exp %b", halt, exp_halt); end
    endtask

    task automatic test_back_to_back_wait0;
        logic [5:0]  exp_ready;
        logic [31:0] exp_data [6];
        exp_ready = 6'b101010;
        exp_data[1] = 32'h0101_0101; exp_data[3] = 32'h0202_0202; exp_data[5] = 32'h0101_0101;
        b_write(32'h4, 32'h0101_0101);
        b_write(32'h8, 32'h0202_0202);
        @(posedge clk); #1;
        req0 = 1'b1; wreq0 = 1'b0; addr0 = 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ready0 !== exp_ready[i]) begin
                errors++; $display("FAIL b2b_ready c%0d got %b exp %b", i, ready0, exp_ready[i]);
            end
            checks++;
            if (stall0 !== ~exp_ready[i]) begin
                errors++; $display("FAIL b2b_stall c%0d got %b exp %b", i, stall0, ~exp_ready[i]);
            end
            if (exp_ready[i]) begin
                checks++;
                if (rdata0 !== exp_data[i]) begin
                    errors++; $display("FAIL b2b_data c%0d got %h exp %h", i, rdata0, exp_data[i]);
                end
            end
            @(posedge clk); #1;
            if (i + 1 == 2) addr0 = 32'h8;
            if (i + 1 == 4) addr0 = 32'h4;
        end
        req0 = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        req0 = 1'b1; wreq0 = 1'b0; addr0 = 32'h8;
        @(posedge clk); #2;
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL mid_ready_pre got %b exp 1", ready0); end
        checks++; if (rdata0 !== 32'h0202_0202) begin errors++; $display("FAIL mid_data_pre got %h exp 02020202", rdata0); end
        rst_n = 1'b0; #1;
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", ready0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", rdata0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err0); end
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL mid_stall got %b exp 1", stall0); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL mid_halt_clear got %b exp 0", halt); end
        checks++; if (halt0 !== 1'b0) begin errors++; $display("FAIL mid_halt0 got %b exp 0", halt0); end
        req0 = 1'b0; #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL mid_stall_lo got %b exp 0", stall0); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_read;
        test_abort;
        test_out_of_range;
        test_halt;
        test_back_to_back_wait0;
        test_reset_mid_access;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
